// File: rtl/gpu_pkg.sv
// Shared definitions for the CPU-side video memory port: memory map, register
// indices, pointer increment codes and the write-port sequencer states.
package gpu_pkg;

  localparam logic [13:0] TILE_BASE   = 14'h0000;
  localparam logic [13:0] TILE_LIMIT  = 14'h07FF;
  localparam logic [13:0] ATTR_BASE   = 14'h1000;
  localparam logic [13:0] ATTR_LIMIT  = 14'h1FFF;
  localparam logic [13:0] COLOR_BASE  = 14'h2000;
  localparam logic [13:0] COLOR_LIMIT = 14'h200F;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam logic [1:0] INCR_0     = 2'd0;
  localparam logic [1:0] INCR_1     = 2'd1;
  localparam logic [1:0] INCR_64    = 2'd2;
  localparam logic [1:0] INCR_1_ALT = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_RD_ISSUE, ST_RD_WAIT} wr_state_e;
  typedef enum logic [1:0] {RGN_NONE, RGN_TILE, RGN_ATTR, RGN_COLOR} region_e;

  typedef struct packed {
    region_e     region;
    logic [11:0] offset;
  } target_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  function automatic target_t decode_target(input logic [13:0] addr);
    target_t t;
    t.region = RGN_NONE;
    t.offset = '0;
    if (addr <= TILE_LIMIT) begin
      t.region = RGN_TILE;
      t.offset = 12'(addr - TILE_BASE);
    end else if (addr >= ATTR_BASE && addr <= ATTR_LIMIT) begin
      t.region = RGN_ATTR;
      t.offset = 12'(addr - ATTR_BASE);
    end else if (addr >= COLOR_BASE && addr <= COLOR_LIMIT) begin
      t.region = RGN_COLOR;
      t.offset = 12'(addr - COLOR_BASE);
    end
    return t;
  endfunction

  function automatic logic [13:0] incr_step(input logic [1:0] code);
    logic [13:0] step;
    step = 14'd1;
    case (code)
      INCR_0:     step = 14'd0;
      INCR_1:     step = 14'd1;
      INCR_64:    step = 14'd64;
      INCR_1_ALT: step = 14'd1;
      default:    step = 14'd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small write-buffer FIFO; push and pop may happen in the same clock, and a
// push into a full FIFO is accepted only when a pop frees a slot that clock.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // NOTE: sequential state is updated only with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after count marks it valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vram_writer.sv
// CPU register port into the tile/attribute/colour memories: buffers writes in
// a FIFO, drains them through the write strobes and prefetches read-back data.
module vram_writer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        write_allow,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        tile_we,
  output logic        attr_we,
  output logic        color_we,
  output logic        tile_re,
  output logic        attr_re,
  output logic        color_re,
  input  logic [7:0]  tile_rdata,
  input  logic [7:0]  attr_rdata,
  input  logic [7:0]  color_rdata
);

  wr_state_e   state_q, state_d;
  region_e     rd_region_q, rd_region_d;
  logic [13:0] ptr_q, ptr_d, step;
  logic [1:0]  incr_q, incr_d;
  logic [7:0]  buffer_q, buffer_d;
  logic        overflow_q, overflow_d, pending_q, pending_d, dirty_q, dirty_d;
  logic        acc_wr, acc_rd, push, pop, pend_set, fifo_full, fifo_empty;
  wr_entry_t   head, push_entry;
  target_t     wr_tgt, rd_tgt;

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(wr_entry_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    acc_wr     = cs & we;
    acc_rd     = cs & ~we;
    step       = incr_step(incr_q);
    push       = acc_wr && (reg_addr == REG_DATA) && !fifo_full;
    push_entry = '{addr: ptr_q, data: cpu_wdata};
    pend_set   = (acc_wr && reg_addr == REG_ADDR_HI) || (acc_rd && reg_addr == REG_DATA);
    ptr_d      = ptr_q;
    incr_d     = incr_q;
    overflow_d = overflow_q;
    if (acc_wr) begin
      case (reg_addr)
        REG_ADDR_LO: ptr_d[7:0]  = cpu_wdata;
        REG_ADDR_HI: ptr_d[13:8] = cpu_wdata[5:0];
        REG_DATA: begin
          if (fifo_full) overflow_d = 1'b1;
          else           ptr_d      = ptr_q + step;
        end
        REG_STATUS:  incr_d = cpu_wdata[1:0];
        default: ;
      endcase
    end else if (acc_rd) begin
      if (reg_addr == REG_DATA)   ptr_d      = ptr_q + step;
      if (reg_addr == REG_STATUS) overflow_d = 1'b0;
    end
  end

  always_comb begin
    case (reg_addr)
      REG_ADDR_LO: cpu_rdata = ptr_q[7:0];
      REG_ADDR_HI: cpu_rdata = {2'b00, ptr_q[13:8]};
      REG_DATA:    cpu_rdata = buffer_q;
      default:     cpu_rdata = {4'b0000, overflow_q, pending_q, fifo_empty, fifo_full};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | pend_set;
    dirty_d     = dirty_q;
    buffer_d    = buffer_q;
    rd_region_d = rd_region_q;
    pop         = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    {tile_we, attr_we, color_we, tile_re, attr_re, color_re} = '0;
    wr_tgt      = decode_target(head.addr);
    rd_tgt      = decode_target(ptr_q);
    case (state_q)
      ST_IDLE: begin
        dirty_d = 1'b0;
        if (!fifo_empty && write_allow)  state_d = ST_WRITE;
        else if (pending_q && fifo_empty) state_d = ST_RD_ISSUE;
      end
      ST_WRITE: begin
        pop      = 1'b1;
        mem_addr = wr_tgt.offset;
        if (wr_tgt.region != RGN_NONE) mem_wdata = head.data;
        tile_we  = (wr_tgt.region == RGN_TILE);
        attr_we  = (wr_tgt.region == RGN_ATTR);
        color_we = (wr_tgt.region == RGN_COLOR);
        state_d  = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        dirty_d     = dirty_q | pend_set;
        rd_region_d = rd_tgt.region;
        mem_addr    = rd_tgt.offset;
        tile_re     = (rd_tgt.region == RGN_TILE);
        attr_re     = (rd_tgt.region == RGN_ATTR);
        color_re    = (rd_tgt.region == RGN_COLOR);
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        dirty_d = dirty_q | pend_set;
        // A pointer move since issue makes this capture stale; keep pending and reissue.
        if (!(dirty_q | pend_set)) begin
          pending_d = 1'b0;
          case (rd_region_q)
            RGN_TILE:  buffer_d = tile_rdata;
            RGN_ATTR:  buffer_d = attr_rdata;
            RGN_COLOR: buffer_d = color_rdata;
            default:   buffer_d = 8'h00;
          endcase
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_region_q <= RGN_NONE;
      ptr_q       <= '0;
      incr_q      <= INCR_1;
      buffer_q    <= '0;
      overflow_q  <= 1'b0;
      pending_q   <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_region_q <= rd_region_d;
      ptr_q       <= ptr_d;
      incr_q      <= incr_d;
      buffer_q    <= buffer_d;
      overflow_q  <= overflow_d;
      pending_q   <= pending_d;
      dirty_q     <= dirty_d;
    end
  end

endmodule
